// File: rtl/scan_mux_n_if.sv
// Channel-data, control and output-handshake bundle for scan_mux_n.
// master = producer/consumer side, slave = the mux itself.
interface scan_mux_n_if #(
    parameter int W = 4,
    parameter int N = 4
);
    localparam int CW = $clog2(N);

    logic [N*W-1:0] IN;
    logic           MODE;
    logic [CW-1:0]  SEL;
    logic           GO;
    logic [N-1:0]   EN;
    logic           O_READY;
    logic [W-1:0]   O;
    logic [CW-1:0]  O_CH;
    logic           O_VALID;
    logic [N-1:0]   ONEHOT;

    modport master (
        output IN, MODE, SEL, GO, EN, O_READY,
        input  O, O_CH, O_VALID, ONEHOT
    );

    modport slave (
        input  IN, MODE, SEL, GO, EN, O_READY,
        output O, O_CH, O_VALID, ONEHOT
    );
endinterface

// File: rtl/scan_mux_n.sv
// N-channel sampling mux: manual single-shot capture or timed round-robin scan
// over an enable mask, with a one-deep valid/ready output register.
module scan_mux_n #(
    parameter int W     = 4,
    parameter int N     = 4,
    parameter int DWELL = 4
) (
    input logic         CLK,
    input logic         RST,
    scan_mux_n_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [1:0]    S_IDLE  = 2'd0;
    localparam logic [1:0]    S_DWELL = 2'd1;
    localparam logic [1:0]    S_HOLD  = 2'd2;
    localparam logic [DW-1:0] DLAST   = DW'(DWELL - 1);
    localparam logic [CW:0]   N_CH    = (CW + 1)'(N);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cur_q, cur_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [W-1:0]  o_q, o_d;
    logic [CW-1:0] o_ch_q, o_ch_d;
    logic          o_valid_q, o_valid_d;
    logic [N-1:0]  onehot_q;

    logic [W-1:0]  ch [N];
    logic          slot_free, scan_ok, sel_ok, cap;
    logic [CW-1:0] cap_ch, first_en, next_en;

    // First enabled channel at offset skip..skip+N-1 from 'from'; returns 'from' if mask is empty.
    function automatic logic [CW-1:0] find_en(input logic [CW-1:0] from,
                                              input logic [N-1:0]  mask,
                                              input int unsigned   skip);
        logic [CW-1:0] r;
        logic          found;
        int unsigned   idx;
        r     = from;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = {{(32-CW){1'b0}}, from};
            idx = (idx + skip + k) % N;
            if (!found && mask[idx[CW-1:0]]) begin
                r     = idx[CW-1:0];
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            ch[i] = bus.IN[i*W +: W];
        end
    end

    assign slot_free = !o_valid_q || bus.O_READY;
    assign scan_ok   = bus.MODE && (bus.EN != '0);
    assign sel_ok    = {1'b0, bus.SEL} < N_CH;
    assign first_en  = find_en(cur_q, bus.EN, 0);
    assign next_en   = find_en(cur_q, bus.EN, 1);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        dcnt_d  = dcnt_q;
        cap     = 1'b0;
        cap_ch  = cur_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.MODE) begin
                    if (bus.GO && slot_free && sel_ok) begin
                        cap    = 1'b1;
                        cap_ch = bus.SEL;
                    end
                end else if (scan_ok) begin
                    cur_d   = first_en;
                    dcnt_d  = '0;
                    state_d = S_DWELL;
                end
            end
            S_DWELL: begin
                if (!scan_ok) begin
                    state_d = S_IDLE;
                end else if (!bus.EN[cur_q]) begin
                    cur_d  = next_en;
                    dcnt_d = '0;
                end else if (dcnt_q == DLAST) begin
                    if (slot_free) begin
                        cap    = 1'b1;
                        cur_d  = next_en;
                        dcnt_d = '0;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (!scan_ok) begin
                    state_d = S_IDLE;
                end else if (slot_free) begin
                    cap     = 1'b1;
                    cur_d   = next_en;
                    dcnt_d  = '0;
                    state_d = S_DWELL;
                end
            end
            default: state_d = S_IDLE;
        endcase

        o_d       = cap ? ch[cap_ch] : o_q;
        o_ch_d    = cap ? cap_ch : o_ch_q;
        o_valid_d = cap || (o_valid_q && !bus.O_READY);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            dcnt_q    <= '0;
            o_q       <= '0;
            o_ch_q    <= '0;
            o_valid_q <= 1'b0;
            onehot_q  <= {{(N-1){1'b0}}, 1'b1};
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            dcnt_q    <= dcnt_d;
            o_q       <= o_d;
            o_ch_q    <= o_ch_d;
            o_valid_q <= o_valid_d;
            onehot_q  <= {{(N-1){1'b0}}, 1'b1} << cur_d;
        end
    end

    assign bus.O       = o_q;
    assign bus.O_CH    = o_ch_q;
    assign bus.O_VALID = o_valid_q;
    assign bus.ONEHOT  = onehot_q;
endmodule
